lv_mem: RTL and testbench



---
 rtl/lv_mem.sv | 43 ++++
 tb/tb_lv_mem.sv | 128 ++++++++++++
 2 files changed

// File: rtl/lv_mem.sv
// Level register for the sequence game: holds level 0..8, armed by on, advanced by up.
// Build option: define LV_MEM_WRAP_EN to wrap 8->1 instead of saturating at 8.
module lv_mem (
   output logic [3:0] lv,
   input  logic       up,
   input  logic       on,
   input  logic       setzero,
   input  logic       reset,
   input  logic       clk
);

   localparam logic [3:0] LV_MAX = 4'd8;

   logic       armed;
   logic [3:0] lv_inc;

   // Next level for an accepted up; out-of-range values recover like the top level.
   always_comb begin
      lv_inc = lv + 4'd1;
      if (lv >= LV_MAX) begin
`ifdef LV_MEM_WRAP_EN
         lv_inc = 4'd1;
`else
         lv_inc = LV_MAX;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lv    <= 4'd0;
         armed <= 1'b0;
      end else if (setzero) begin
         lv    <= 4'd0;
      end else if (on) begin
         lv    <= 4'd1;
         armed <= 1'b1;
      end else if (up && armed) begin
         lv    <= lv_inc;
      end
   end

endmodule

// File: tb/tb_lv_mem.sv
// Directed bench for lv_mem: driver queues hand-computed levels, monitor checks lv after each edge.
module tb_lv_mem;

   logic       clk = 1'b0;
   logic       reset, up, on, setzero;
   logic [3:0] lv;

   typedef struct {
      logic [3:0] exp;
      string      name;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   lv_mem dut (
      .lv(lv), .up(up), .on(on), .setzero(setzero), .reset(reset), .clk(clk)
   );

   always #5 clk = ~clk;

   // Monitor: one expected level per rising edge once stimulus starts.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (lv !== e.exp) begin
               errors++;
               $display("FAIL %s: lv=%0d expected %0d", e.name, lv, e.exp);
            end
         end
      end
   end

   task automatic step(input logic r, input logic s, input logic o, input logic u,
                       input logic [3:0] exp, input string name);
      exp_t e;
      @(negedge clk);
      reset = r; setzero = s; on = o; up = u;
      e.exp = exp; e.name = name;
      q.push_back(e);
   endtask

   initial begin
      reset = 1'b0; up = 1'b0; on = 1'b0; setzero = 1'b0;

      // Reset with up held, then up alone must not count while disarmed
      step(1, 0, 0, 1, 4'd0, "reset_with_up");
      for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 4'd0, "up_disarmed");

      // Arm and count
      step(0, 0, 1, 0, 4'd1, "arm");
      step(0, 0, 0, 1, 4'd2, "count2");
      step(0, 0, 0, 1, 4'd3, "count3");
      step(0, 0, 0, 1, 4'd4, "count4");
      step(0, 0, 0, 0, 4'd4, "hold_idle");

      // Top of range: re-arm then ten ups
      step(0, 0, 1, 0, 4'd1, "rearm");
`ifdef LV_MEM_WRAP_EN
      step(0, 0, 0, 1, 4'd2, "wrap_up1");
      step(0, 0, 0, 1, 4'd3, "wrap_up2");
      step(0, 0, 0, 1, 4'd4, "wrap_up3");
      step(0, 0, 0, 1, 4'd5, "wrap_up4");
      step(0, 0, 0, 1, 4'd6, "wrap_up5");
      step(0, 0, 0, 1, 4'd7, "wrap_up6");
      step(0, 0, 0, 1, 4'd8, "wrap_up7");
      step(0, 0, 0, 1, 4'd1, "wrap_up8");
      step(0, 0, 0, 1, 4'd2, "wrap_up9");
      step(0, 0, 0, 1, 4'd3, "wrap_up10");
`else
      step(0, 0, 0, 1, 4'd2, "sat_up1");
      step(0, 0, 0, 1, 4'd3, "sat_up2");
      step(0, 0, 0, 1, 4'd4, "sat_up3");
      step(0, 0, 0, 1, 4'd5, "sat_up4");
      step(0, 0, 0, 1, 4'd6, "sat_up5");
      step(0, 0, 0, 1, 4'd7, "sat_up6");
      step(0, 0, 0, 1, 4'd8, "sat_up7");
      step(0, 0, 0, 1, 4'd8, "sat_up8");
      step(0, 0, 0, 1, 4'd8, "sat_up9");
      step(0, 0, 0, 1, 4'd8, "sat_up10");
`endif

      // Setzero keeps armed, counting resumes from 0
      step(0, 0, 1, 0, 4'd1, "arm_sz");
      step(0, 0, 0, 1, 4'd2, "sz_pre2");
      step(0, 0, 0, 1, 4'd3, "sz_pre3");
      step(0, 0, 0, 1, 4'd4, "sz_pre4");
      step(0, 0, 0, 1, 4'd5, "sz_pre5");
      step(0, 1, 0, 0, 4'd0, "setzero");
      step(0, 0, 0, 1, 4'd1, "sz_up1");
      step(0, 0, 0, 1, 4'd2, "sz_up2");

      // Priority
      step(0, 1, 1, 1, 4'd0, "prio_sz_on_up");
      step(0, 0, 0, 1, 4'd1, "prio_still_armed");
      step(0, 0, 0, 1, 4'd2, "prio_up2");
      step(0, 0, 1, 1, 4'd1, "prio_on_up");
      step(1, 1, 1, 1, 4'd0, "prio_reset_all");
      step(0, 0, 0, 1, 4'd0, "prio_disarmed");

      // Reset mid-count with up held
      step(0, 0, 1, 0, 4'd1, "mid_arm");
      for (int i = 2; i <= 6; i++) step(0, 0, 0, 1, 4'(i), "mid_count");
      step(1, 0, 0, 1, 4'd0, "mid_reset1");
      step(1, 0, 0, 1, 4'd0, "mid_reset2");
      for (int i = 0; i < 30; i++) step(0, 0, 0, 1, 4'd0, "mid_up_disarmed");
      step(0, 0, 1, 0, 4'd1, "mid_rearm");
      step(0, 0, 0, 0, 4'd1, "final_hold");

      // Let the monitor drain; a leftover entry means it missed edges
      repeat (3) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: pending=%0d expected 0", q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
